regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4: cycles an I/O requester may wait before the CPU is stalled.
REQ-002 SHALL have ports: clock  in  1  single system clock; all state on rising edge.
REQ-003 SHALL have ports: ctrl_reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: cpu_we  in  1 / cpu_reg  in  5 / cpu_data  in  32  CPU writeback request.
REQ-005 SHALL have ports: io0_req  in  1 / io0_reg  in  5 / io0_data  in  32 / io0_ack  out  1  I/O requester 0.
REQ-006 SHALL have ports: io1_req  in  1 / io1_reg  in  5 / io1_data  in  32 / io1_ack  out  1  I/O requester 1.
REQ-007 SHALL have ports: cpu_stall  out  1  CPU must hold its writeback and stall while high.
REQ-008 SHALL have ports: ctrl_writeEnable  out  1 / ctrl_writeReg  out  5 / data_writeReg  out  32  register-file write port.

Function
REQ-009 SHALL register all outputs; a grant decided in cycle N appears on the write port and the ack in cycle N+1, giving 1-cycle latency.
REQ-010 SHALL treat the CPU as requesting only when cpu_we=1, cpu_reg!=0 and cpu_stall=0.
REQ-011 SHALL grant the CPU unconditionally when it requests in state NORMAL.
REQ-012 SHALL otherwise grant I/O requesters round-robin.
- Pointer starts at io0.
- After an I/O grant, the pointer moves to the other requester.
- If only one requester is active, it is granted regardless of the pointer.
REQ-013 SHALL hold the ioN handshake: ioN_req, ioN_reg and ioN_data stable until ioN_ack.
- ioN_ack is a single-cycle pulse coincident with the write.
- req still high in the cycle after ack is a new transaction.
REQ-014 SHALL acknowledge an I/O request to register 0 normally but drive ctrl_writeEnable=0 for it (write dropped).
REQ-015 SHALL keep a per-requester wait counter.
- Increments each cycle ioN_req=1 and ioN is not granted.
- Clears on grant or when req=0.
- Saturates at MAX_WAIT.
REQ-016 SHALL implement FSM state NORMAL.
- cpu_stall=0.
- Goes to STALL on the edge at which any wait counter equals MAX_WAIT.
REQ-017 SHALL implement FSM state STALL.
- cpu_stall=1.
- CPU requests are ignored.
- The starving requester is granted; if both are starving, the round-robin pointer decides.
- Returns to NORMAL on the edge after the grant to the last starving requester.
REQ-018 SHALL drive ctrl_writeEnable=0, with ctrl_writeReg and data_writeReg holding their last values, in cycles with no grant.
REQ-019 SHALL never grant more than one source per cycle.
REQ-020 SHALL never assert io0_ack and io1_ack in the same cycle.
REQ-021 SHALL keep ctrl_writeReg=0 with ctrl_writeEnable=1 impossible.
REQ-022 SHALL deassert cpu_stall within MAX_WAIT+2 cycles of assertion when no new request arrives.

Reset
REQ-023 SHALL, while ctrl_reset_n=0, asynchronously force outputs to 0:
- ctrl_writeEnable, ctrl_writeReg, data_writeReg
- io0_ack, io1_ack
- cpu_stall
REQ-024 SHALL, while ctrl_reset_n=0, asynchronously force internal state:
- FSM to NORMAL
- Both wait counters to 0
- Round-robin pointer to io0
REQ-025 SHALL discard an in-flight request on reset mid-transaction without acking it; the requester re-arbitrates after release.
REQ-026 SHALL leave the first grant possible on the first rising edge after ctrl_reset_n rises.

Verification
REQ-027 SHALL cover CPU only: cpu_we=1, cpu_reg=5, cpu_data=0xDEADBEEF -> next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF; acks 0.
REQ-028 SHALL cover simultaneous requests: cpu_we=1 (reg 3), io0_req (reg 20, 0x11), io1_req (reg 22, 0x22), CPU idle from cycle 2.
- CPU write first.
- Then io0 (reg 20), then io1 (reg 22) on consecutive cycles.
- One ack each.
REQ-029 SHALL cover starvation with MAX_WAIT=4: cpu_we=1 every cycle, io1_req=1 (reg 22, 0x7) held.
- cpu_stall rises after 4 waiting cycles.
- Next cycle: io1_ack=1, write reg 22 = 0x7.
- cpu_stall drops the following cycle.
REQ-030 SHALL cover register 0: io0_req with io0_reg=0 -> io0_ack=1, ctrl_writeEnable=0; cpu_we=1 with cpu_reg=0 -> no write.
REQ-031 SHALL cover reset: pull ctrl_reset_n low while io1_req pending with counter=3 and cpu_stall=1.
- All outputs immediately 0.
- No ack.
- After release, io1 is granted within 1 cycle if CPU idle.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: CPU writeback vs two I/O requesters.
// CPU has priority; I/O round-robin; starving I/O stalls the CPU.
module regfile_write_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_reg,
  input  logic [31:0] cpu_data,
  input  logic        io0_req,
  input  logic [4:0]  io0_reg,
  input  logic [31:0] io0_data,
  output logic        io0_ack,
  input  logic        io1_req,
  input  logic [4:0]  io1_reg,
  input  logic [31:0] io1_data,
  output logic        io1_ack,
  output logic        cpu_stall,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  typedef enum logic {
    NORMAL,
    STALL
  } state_e;

  state_e             state_q, state_d;
  logic               rr_q, rr_d;
  logic [1:0][WW-1:0] wait_q, wait_d;
  logic [1:0]         ack_q, ack_d;
  logic               stall_q, stall_d;
  logic               we_q, we_d;
  logic [4:0]         reg_q, reg_d;
  logic [31:0]        data_q, data_d;

  logic [1:0] io_req;
  logic [1:0] starve;
  logic [1:0] gnt_io;
  logic       gnt_cpu;
  logic       cpu_req;
  logic       any_max_q;
  logic       any_max_d;

  function automatic logic [1:0] pick(
    input logic [1:0] r,
    input logic       p
  );
    if (r == 2'b11) return p ? 2'b10 : 2'b01;
    return r;
  endfunction

  always_comb begin
    // req is still high in the ack cycle; that is the old transaction
    io_req[0] = io0_req & ~ack_q[0];
    io_req[1] = io1_req & ~ack_q[1];
    cpu_req   = cpu_we & (cpu_reg != 5'd0) & ~stall_q;
    for (int i = 0; i < 2; i++) begin
      starve[i] = io_req[i] & (wait_q[i] == WMAX);
    end

    gnt_cpu = 1'b0;
    gnt_io  = 2'b00;
    unique case (state_q)
      NORMAL: begin
        if (cpu_req) gnt_cpu = 1'b1;
        else         gnt_io  = pick(io_req, rr_q);
      end
      STALL: gnt_io = pick(starve, rr_q);
    endcase

    any_max_q = 1'b0;
    any_max_d = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_d[i] = '0;
      if (io_req[i] && !gnt_io[i]) begin
        wait_d[i] = (wait_q[i] == WMAX) ? WMAX
                                         : wait_q[i] + 1'b1;
      end
      any_max_q = any_max_q | (wait_q[i] == WMAX);
      any_max_d = any_max_d | (wait_d[i] == WMAX);
    end

    state_d = state_q;
    unique case (state_q)
      NORMAL: if (any_max_d) state_d = STALL;
      STALL: begin
        if (!any_max_q && !any_max_d) state_d = NORMAL;
      end
    endcase

    rr_d = rr_q;
    if (gnt_io[0]) rr_d = 1'b1;
    if (gnt_io[1]) rr_d = 1'b0;

    we_d   = 1'b0;
    reg_d  = reg_q;
    data_d = data_q;
    unique case (1'b1)
      gnt_cpu: begin
        we_d   = 1'b1;
        reg_d  = cpu_reg;
        data_d = cpu_data;
      end
      gnt_io[0]: begin
        we_d   = io0_reg != 5'd0;
        reg_d  = io0_reg;
        data_d = io0_data;
      end
      gnt_io[1]: begin
        we_d   = io1_reg != 5'd0;
        reg_d  = io1_reg;
        data_d = io1_data;
      end
      default: begin
        we_d = 1'b0;
      end
    endcase

    ack_d   = gnt_io;
    stall_d = state_d == STALL;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q <= NORMAL;
      rr_q    <= 1'b0;
      wait_q  <= '0;
      ack_q   <= 2'b00;
      stall_q <= 1'b0;
      we_q    <= 1'b0;
      reg_q   <= 5'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      wait_q  <= wait_d;
      ack_q   <= ack_d;
      stall_q <= stall_d;
      we_q    <= we_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
    end
  end

  assign io0_ack          = ack_q[0];
  assign io1_ack          = ack_q[1];
  assign cpu_stall        = stall_q;
  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = reg_q;
  assign data_writeReg    = data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        cpu_we;
  logic [4:0]  cpu_reg;
  logic [31:0] cpu_data;
  logic        io0_req;
  logic [4:0]  io0_reg;
  logic [31:0] io0_data;
  logic        io0_ack;
  logic        io1_req;
  logic [4:0]  io1_reg;
  logic [31:0] io1_data;
  logic        io1_ack;
  logic        cpu_stall;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.MAX_WAIT(4)) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .cpu_we           (cpu_we),
    .cpu_reg          (cpu_reg),
    .cpu_data         (cpu_data),
    .io0_req          (io0_req),
    .io0_reg          (io0_reg),
    .io0_data         (io0_data),
    .io0_ack          (io0_ack),
    .io1_req          (io1_req),
    .io1_reg          (io1_reg),
    .io1_data         (io1_data),
    .io1_ack          (io1_ack),
    .cpu_stall        (cpu_stall),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic outs(
    input string       tag,
    input logic        we,
    input logic [4:0]  rg,
    input logic [31:0] dt,
    input logic        a0,
    input logic        a1,
    input logic        st
  );
    chk({tag, ".we"}, 32'(ctrl_writeEnable), 32'(we));
    chk({tag, ".reg"}, 32'(ctrl_writeReg), 32'(rg));
    chk({tag, ".data"}, data_writeReg, dt);
    chk({tag, ".ack0"}, 32'(io0_ack), 32'(a0));
    chk({tag, ".ack1"}, 32'(io1_ack), 32'(a1));
    chk({tag, ".stall"}, 32'(cpu_stall), 32'(st));
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    cpu_we = 0; cpu_reg = 0; cpu_data = 0;
    io0_req = 0; io0_reg = 0; io0_data = 0;
    io1_req = 0; io1_reg = 0; io1_data = 0;
    tick();
    outs("rst", 0, 0, 0, 0, 0, 0);
    tick();
    ctrl_reset_n = 1'b1;

    // CPU only
    cpu_we = 1; cpu_reg = 5; cpu_data = 32'hDEADBEEF;
    tick();
    outs("cpu", 1, 5, 32'hDEADBEEF, 0, 0, 0);
    cpu_we = 0;
    tick();
    outs("idle_hold", 0, 5, 32'hDEADBEEF, 0, 0, 0);

    // simultaneous CPU, io0, io1
    cpu_we = 1; cpu_reg = 3; cpu_data = 32'h33;
    io0_req = 1; io0_reg = 20; io0_data = 32'h11;
    io1_req = 1; io1_reg = 22; io1_data = 32'h22;
    tick();
    outs("sim_cpu", 1, 3, 32'h33, 0, 0, 0);
    cpu_we = 0;
    tick();
    outs("sim_io0", 1, 20, 32'h11, 1, 0, 0);
    io0_req = 0;
    tick();
    outs("sim_io1", 1, 22, 32'h22, 0, 1, 0);
    io1_req = 0;
    tick();
    outs("sim_done", 0, 22, 32'h22, 0, 0, 0);

    // starvation of io1 behind a busy CPU
    cpu_we = 1; cpu_reg = 7; cpu_data = 32'h77;
    io1_req = 1; io1_reg = 22; io1_data = 32'h7;
    for (int i = 1; i <= 3; i++) begin
      tick();
      outs($sformatf("starve_c%0d", i), 1, 7, 32'h77, 0, 0, 0);
    end
    tick();
    outs("starve_stall", 1, 7, 32'h77, 0, 0, 1);
    tick();
    outs("starve_grant", 1, 22, 32'h7, 0, 1, 1);
    io1_req = 0;
    tick();
    outs("starve_release", 0, 22, 32'h7, 0, 0, 0);
    tick();
    outs("starve_cpu_back", 1, 7, 32'h77, 0, 0, 0);
    cpu_we = 0;
    tick();

    // register 0 from io0, then from the CPU
    io0_req = 1; io0_reg = 0; io0_data = 32'h55;
    tick();
    outs("r0_io", 0, 0, 32'h55, 1, 0, 0);
    io0_req = 0;
    cpu_we = 1; cpu_reg = 0; cpu_data = 32'h66;
    tick();
    outs("r0_cpu_a", 0, 0, 32'h55, 0, 0, 0);
    tick();
    outs("r0_cpu_b", 0, 0, 32'h55, 0, 0, 0);
    cpu_we = 0;

    // pointer now at io1 after the io0 grant
    io0_req = 1; io0_reg = 9; io0_data = 32'h90;
    io1_req = 1; io1_reg = 10; io1_data = 32'hA0;
    tick();
    outs("rr_io1", 1, 10, 32'hA0, 0, 1, 0);
    io1_req = 0;
    tick();
    outs("rr_io0", 1, 9, 32'h90, 1, 0, 0);
    io0_req = 0;
    tick();

    // reset while stalled with io1 pending at count 3
    cpu_we = 1; cpu_reg = 4; cpu_data = 32'h44;
    io0_req = 1; io0_reg = 1; io0_data = 32'h1;
    tick();
    io1_req = 1; io1_reg = 2; io1_data = 32'h2;
    tick();
    tick();
    tick();
    outs("pre_rst", 1, 4, 32'h44, 0, 0, 1);
    ctrl_reset_n = 1'b0;
    cpu_we = 0;
    io0_req = 0;
    #1;
    outs("mid_rst", 0, 0, 0, 0, 0, 0);
    tick();
    outs("in_rst", 0, 0, 0, 0, 0, 0);
    ctrl_reset_n = 1'b1;
    tick();
    outs("post_rst", 1, 2, 32'h2, 0, 1, 0);
    io1_req = 0;
    tick();
    outs("post_idle", 0, 2, 32'h2, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
